// File: rtl/spi_slave.sv
// spi_slave: SPI responder (CPOL=0), oversampled in the clk domain.
// Receives 8-bit MSB-first frames on mosi (sampled at sclk falling edges) and
// returns queued tx bytes on miso (updated after each sclk falling edge).
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   tx_data/tx_valid  byte for the next frame; accepted when tx_valid && tx_ready
//   tx_ready          1-entry tx buffer is empty
//   rx_data/rx_valid  last complete received byte; rx_valid pulses 1 cycle on update
//   busy              high while the synchronized cs_n is low
//   frame_err         1-cycle pulse: cs_n rose with a partial byte
//   tx_underrun       1-cycle pulse: a byte started with an empty tx buffer
//   sclk, mosi, cs_n  SPI inputs from the master
//   miso, miso_oe     SPI output and its enable (high only while selected)
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       tx_underrun,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       cs_n
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_fall, cs_fall, cs_rise;

  logic [6:0] shift_tx;   // bits still to be sent after the one on miso
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic [7:0] tx_buf;
  logic       tx_full;

  logic       load_tx;
  logic [7:0] tx_src;

  // Input synchronizers followed by one edge-detect flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;

  assign tx_ready = ~tx_full;
  assign tx_src   = tx_full ? tx_buf : DEFAULT_TX;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; load_tx marks every point where a new byte starts
  always_comb begin
    state_nxt = state;
    load_tx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          load_tx   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
        end else if (sclk_fall && bit_cnt == 3'd0) begin
          load_tx = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy    = 1'b0;
    miso_oe = 1'b0;
    if (state == SHIFT) begin
      busy    = 1'b1;
      miso_oe = 1'b1;
    end
  end

  // Datapath: tx buffer, shift registers, bit counter, pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      shift_tx    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= 3'd7;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= load_tx & ~tx_full;

      // Load and consume are exclusive (load needs empty, consume frees full);
      // an empty-buffer consume with a same-cycle load sends DEFAULT_TX.
      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (load_tx) begin
        tx_full <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            miso     <= tx_src[7];
            shift_tx <= tx_src[6:0];
            bit_cnt  <= 3'd7;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            miso      <= 1'b0;
            frame_err <= (bit_cnt != 3'd7);
            bit_cnt   <= 3'd7;
          end else if (sclk_fall) begin
            rx_shift <= {rx_shift[5:0], mosi_s};
            if (bit_cnt == 3'd0) begin
              rx_data  <= {rx_shift, mosi_s};
              rx_valid <= 1'b1;
              miso     <= tx_src[7];
              shift_tx <= tx_src[6:0];
              bit_cnt  <= 3'd7;
            end else begin
              miso     <= shift_tx[6];
              shift_tx <= {shift_tx[5:0], 1'b0};
              bit_cnt  <= bit_cnt - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
